// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        MEM_WAIT,
        HALT
    } state_t;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // Wide enough for the largest legal TIMEOUT_CYCLES (65535).
    localparam int unsigned WAIT_CNT_W = 16;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline controller and the datapath.
// master: the controller (consumes hazard info, drives enables/flushes).
// slave:  the datapath side.
interface pipeline_ctrl_if;
    import pipe_pkg::*;

    reg_idx_t id_rs;
    reg_idx_t id_rt;
    logic     id_uses_rt;
    logic     ex_mem_read;
    reg_idx_t ex_rt;
    logic     branch_taken;
    logic     dmem_req;
    logic     dmem_ready;

    logic     pc_write;
    logic     ifid_enable;
    logic     idex_enable;
    logic     exmem_enable;
    logic     memwb_enable;
    logic     ifid_flush;
    logic     idex_flush;
    logic     exmem_flush;
    logic     memwb_flush;
    logic     mem_timeout;

    modport master (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               branch_taken, dmem_req, dmem_ready,
        output pc_write, ifid_enable, idex_enable, exmem_enable, memwb_enable,
               ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_timeout
    );

    modport slave (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               branch_taken, dmem_req, dmem_ready,
        input  pc_write, ifid_enable, idex_enable, exmem_enable, memwb_enable,
               ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_timeout
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use hazard compare: a load in ID_EX whose destination
// is a live source of the instruction in IF_ID. r0 never creates a hazard.
module hazard_detect
    import pipe_pkg::*;
(
    input  reg_idx_t id_rs,
    input  reg_idx_t id_rt,
    input  logic     id_uses_rt,
    input  logic     ex_mem_read,
    input  reg_idx_t ex_rt,
    output logic     load_use
);

    // Match the load destination against both possible sources.
    always_comb begin
        load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard and sequencing controller for the 5-stage pipeline.
// Priority in RUN: memory wait > taken branch > load-use > normal advance.
// Optional feature macro: PIPE_CTRL_STATS_EN adds the stall_count port.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned STALL_CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef PIPE_CTRL_STATS_EN
    output logic [STALL_CNT_W-1:0] stall_count,
`endif
    pipeline_ctrl_if.master        bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("pipeline_ctrl: TIMEOUT_CYCLES out of range 1..65535");
    end
    if (STALL_CNT_W < 1) begin : g_bad_cnt_w
        $error("pipeline_ctrl: STALL_CNT_W must be at least 1");
    end

    localparam logic [WAIT_CNT_W:0] TIMEOUT_LIM = (WAIT_CNT_W+1)'(TIMEOUT_CYCLES);

    state_t                state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_q, wait_d;
    logic [WAIT_CNT_W:0]   wait_inc;
    logic                  load_use;
    logic                  mem_block;
    logic                  freeze;
    logic                  release_decode;

    hazard_detect u_hazard (
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rt  (bus.id_uses_rt),
        .ex_mem_read (bus.ex_mem_read),
        .ex_rt       (bus.ex_rt),
        .load_use    (load_use)
    );

    // State and watchdog counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next state, watchdog update and output decode.
    always_comb begin
        mem_block = bus.dmem_req && !bus.dmem_ready;
        wait_inc  = {1'b0, wait_q} + 1'b1;

        // RUN with an unblocked memory and the MEM_WAIT release cycle share
        // one decode; the frozen registers' pending branch/load-use act here.
        freeze         = ((state_q == RUN) && mem_block) ||
                         ((state_q == MEM_WAIT) && !bus.dmem_ready);
        release_decode = ((state_q == RUN) || (state_q == MEM_WAIT)) && !freeze;

        state_d          = state_q;
        wait_d           = wait_q;
        bus.pc_write     = 1'b1;
        bus.ifid_enable  = 1'b1;
        bus.idex_enable  = 1'b1;
        bus.exmem_enable = 1'b1;
        bus.memwb_enable = 1'b1;
        bus.ifid_flush   = 1'b0;
        bus.idex_flush   = 1'b0;
        bus.exmem_flush  = 1'b0;
        bus.memwb_flush  = 1'b0;
        bus.mem_timeout  = 1'b0;

        case (state_q)
            INIT: begin
                state_d = RUN;
                wait_d  = '0;
            end
            RUN: begin
                if (mem_block) begin
                    // The entry cycle is the first not-ready cycle.
                    wait_d  = WAIT_CNT_W'(1);
                    state_d = (TIMEOUT_CYCLES == 1) ? HALT : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (!bus.dmem_ready) begin
                    wait_d = wait_inc[WAIT_CNT_W-1:0];
                    if (wait_inc >= TIMEOUT_LIM) begin
                        state_d = HALT;
                    end
                end else begin
                    wait_d  = '0;
                    state_d = RUN;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = INIT;
            end
        endcase

        if (state_q == INIT) begin
            bus.pc_write     = 1'b0;
            bus.ifid_enable  = 1'b0;
            bus.idex_enable  = 1'b0;
            bus.exmem_enable = 1'b0;
            bus.memwb_enable = 1'b0;
            bus.ifid_flush   = 1'b1;
            bus.idex_flush   = 1'b1;
            bus.exmem_flush  = 1'b1;
            bus.memwb_flush  = 1'b1;
        end else if (state_q == HALT) begin
            bus.pc_write     = 1'b0;
            bus.ifid_enable  = 1'b0;
            bus.idex_enable  = 1'b0;
            bus.exmem_enable = 1'b0;
            bus.memwb_enable = 1'b0;
            bus.mem_timeout  = 1'b1;
        end else if (freeze) begin
            bus.pc_write     = 1'b0;
            bus.ifid_enable  = 1'b0;
            bus.idex_enable  = 1'b0;
            bus.exmem_enable = 1'b0;
            bus.memwb_flush  = 1'b1;
        end else if (release_decode) begin
            if (bus.branch_taken) begin
                bus.ifid_flush  = 1'b1;
                bus.idex_flush  = 1'b1;
                bus.exmem_flush = 1'b1;
            end else if (load_use) begin
                bus.pc_write    = 1'b0;
                bus.ifid_enable = 1'b0;
                bus.idex_flush  = 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    logic [STALL_CNT_W-1:0] stall_q;

    // Saturating count of cycles the PC is held while RUN/MEM_WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (((state_q == RUN) || (state_q == MEM_WAIT)) &&
                     !bus.pc_write && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the 5-stage pipeline: drives the PC write enable and the enable/flush inputs of the IF_ID, ID_EX, EX_MEM and MEM_WB registers. Resolves load-use stalls, taken-branch flushes and multi-cycle data-memory waits under one fixed priority. Includes a watchdog that halts the pipeline on a memory that never answers. Sits beside the datapath in the top level; it contains no datapath state.

## Interface
- TIMEOUT_CYCLES, 255: maximum consecutive MEM_WAIT cycles before halting; legal range 1..65535.
- STALL_CNT_W, 32: width of the stall statistics counter.

- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- id_rs, id_rt  in  5 each  source registers of the instruction held in IF_ID
- id_uses_rt  in  1  1 when id_rt is a true source
- ex_mem_read  in  1  instruction in ID_EX is a load
- ex_rt  in  5  load destination register
- branch_taken  in  1  taken branch resolved, from EX_MEM
- dmem_req  in  1  MEM stage requests a data-memory access
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write, ifid_enable, idex_enable, exmem_enable, memwb_enable  out  1 each  register load enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble (all-zero control) instead of the input
- mem_timeout  out  1  sticky error flag
- stall_count  out  STALL_CNT_W  stall statistics counter (present only with the macro)

## Operation
- FSM states: INIT, RUN, MEM_WAIT, HALT. Reset (rst=1 at an edge) sets INIT from any state, including mid-wait.
- INIT: pc_write=0, all enables=0, all flushes=1. Lasts exactly one cycle, then goes to RUN.
- Outputs are combinational from state and inputs. Every flag not listed below is 0, except the enables, which default to 1.
- Priority in RUN, highest first:
  - **Memory wait** (dmem_req && !dmem_ready): pc_write and all enables=0 except memwb_enable=1, memwb_flush=1. Next state MEM_WAIT. Wait counter loads 1.
  - **Branch** (branch_taken): ifid_flush, idex_flush, exmem_flush=1, pc_write=1. Load-use is ignored this cycle.
  - **Load-use** (ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt))): pc_write=0, ifid_enable=0, idex_flush=1.
  - Otherwise all enables are 1.
- MEM_WAIT:
  - dmem_ready=0: same freeze outputs as above. The wait counter increments; when it reaches TIMEOUT_CYCLES, go to HALT.
  - dmem_ready=1: outputs are decoded as in RUN with the memory condition treated as satisfied, so a branch or load-use pending in the frozen registers is acted on in this release cycle. Next state RUN.
  - branch_taken is not acted on while frozen; it stays asserted because EX_MEM holds.
- HALT: pc_write and all enables=0, no flushes, mem_timeout=1. Exits only through rst.
- mem_timeout resets to 0.

## Timing
- Load-use stall: 1 bubble per hazard. The condition clears on the next cycle because the load advances.
- Branch penalty: 3 flushed instructions. The target is loaded into the PC in the same cycle.
- Memory wait: freeze lasts exactly until the first cycle with dmem_ready=1, which is the release cycle. A request with dmem_ready=1 on its first cycle costs 0 stall cycles.
- Timeout: HALT is entered at the edge ending the TIMEOUT_CYCLES-th consecutive not-ready cycle.
- dmem_ready=1 in the same cycle the counter hits the limit: release wins, no HALT.

## Configuration
- PIPE_CTRL_STATS_EN defined:
  - stall_count exists.
  - Increments by 1 in every cycle where pc_write=0 and the state is RUN or MEM_WAIT.
  - Saturates at all-ones and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package pipe_pkg holds:
  - the state enum (INIT, RUN, MEM_WAIT, HALT);
  - the 5-bit register-index typedef;
  - the constant REG_ZERO=0.
- One sub-module, hazard_detect: purely combinational load-use compare with output load_use. The FSM, watchdog counter and output decode stay in pipeline_ctrl.

## Test plan
- Reset: assert rst 2 cycles, then release -> one INIT cycle with all flushes=1 and pc_write=0, then RUN with all enables=1, mem_timeout=0, stall_count=0.
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 -> one cycle with pc_write=0, ifid_enable=0, idex_flush=1. Same stimulus with ex_rt=0 -> no stall.
- Branch and load-use together: branch_taken=1 plus a load-use match -> three flushes, pc_write=1, no stall.
- Memory wait: dmem_req=1 with dmem_ready held low 4 cycles -> 4 freeze cycles with memwb_flush=1, then release. stall_count=4 with PIPE_CTRL_STATS_EN defined.
- Timeout: TIMEOUT_CYCLES=8, dmem_ready never asserted -> HALT after 8 wait cycles, mem_timeout=1 and held. rst -> INIT.
- Reset mid-wait: rst during MEM_WAIT -> INIT next cycle, wait counter cleared, no HALT.
